// File: rtl/mem_stage_pkg.sv
// Shared Y86-64 encodings for the memory stage: icodes, status codes,
// register sentinel and the bubble value of each pipeline-register field.
package mem_stage_pkg;

  localparam int unsigned DATA_BUS = 64;
  localparam int unsigned ADDR_BUS = 64;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] BUBBLE_STAT  = SAOK;
  localparam logic [3:0] BUBBLE_ICODE = INOP;
  localparam logic [3:0] BUBBLE_REG   = RNONE;

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
  endfunction

  // POPQ and RET address the stack through the old %rsp carried in valA.
  function automatic logic uses_vala_addr(input logic [3:0] icode);
    return (icode == IPOPQ) || (icode == IRET);
  endfunction

endpackage

// File: rtl/mem_stage_pipe_reg.sv
// Width-parameterised pipeline register with async reset, stall and bubble;
// reset and bubble both load the BUBBLE value, bubble wins over stall.
module pipe_reg
  import mem_stage_pkg::*;
#(
  parameter int unsigned    W      = 8,
  parameter logic [W-1:0]   BUBBLE = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         stall_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (bubble_i) begin
      data_d = BUBBLE;
    end else if (!stall_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= BUBBLE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: E->M register, data-RAM access decode, status merge,
// M->W register and the sticky architectural exception state.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_BUS,
  parameter int unsigned ADDR_W = ADDR_BUS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        e_stat_i,
  input  logic [3:0]        e_icode_i,
  input  logic [DATA_W-1:0] e_valE_i,
  input  logic [DATA_W-1:0] e_valA_i,
  input  logic [3:0]        e_dstE_i,
  input  logic [3:0]        e_dstM_i,
  input  logic              m_stall_i,
  input  logic              m_bubble_i,
  input  logic              w_stall_i,
  output logic              dmem_r_en_o,
  output logic              dmem_w_en_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_error_i,
  output logic [2:0]        m_stat_o,
  output logic [3:0]        m_icode_o,
  output logic [DATA_W-1:0] m_valE_o,
  output logic [DATA_W-1:0] m_valM_o,
  output logic [3:0]        m_dstE_o,
  output logic [3:0]        m_dstM_o,
  output logic [2:0]        W_stat_o,
  output logic [3:0]        W_icode_o,
  output logic [DATA_W-1:0] W_valE_o,
  output logic [DATA_W-1:0] W_valM_o,
  output logic [3:0]        W_dstE_o,
  output logic [3:0]        W_dstM_o,
  output logic [2:0]        cpu_stat_o
);

  // Both registers are {stat, icode, data, data, reg, reg}.
  localparam int unsigned PR_W = 3 + 4 + 2 * DATA_W + 4 + 4;
  localparam logic [PR_W-1:0] PR_BUBBLE =
    {BUBBLE_STAT, BUBBLE_ICODE, {DATA_W{1'b0}}, {DATA_W{1'b0}}, BUBBLE_REG, BUBBLE_REG};

  logic [PR_W-1:0]   m_reg;
  logic [2:0]        mr_stat;
  logic [3:0]        mr_icode;
  logic [DATA_W-1:0] mr_valE;
  logic [DATA_W-1:0] mr_valA;
  logic [3:0]        mr_dstE;
  logic [3:0]        mr_dstM;

  logic [PR_W-1:0]   w_next;
  logic [PR_W-1:0]   w_reg;
  logic              w_hold;

  logic              mem_rd;
  logic              mem_wr;
  logic              exc_d;
  logic              exc_q;

  pipe_reg #(
    .W      (PR_W),
    .BUBBLE (PR_BUBBLE)
  ) u_m_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .stall_i  (m_stall_i),
    .bubble_i (m_bubble_i),
    .d_i      ({e_stat_i, e_icode_i, e_valE_i, e_valA_i, e_dstE_i, e_dstM_i}),
    .q_o      (m_reg)
  );

  assign {mr_stat, mr_icode, mr_valE, mr_valA, mr_dstE, mr_dstM} = m_reg;

  always_comb begin
    mem_rd       = is_mem_read(mr_icode);
    mem_wr       = is_mem_write(mr_icode);
    dmem_r_en_o  = mem_rd & ~rst_i;
    // Stores must never commit behind or under an exception.
    dmem_w_en_o  = mem_wr & ~dmem_error_i & ~exc_q & ~rst_i
                 & (mr_stat == SAOK) & (W_stat_o == SAOK);
    dmem_addr_o  = ADDR_W'(uses_vala_addr(mr_icode) ? mr_valA : mr_valE);
    dmem_wdata_o = mr_valA;
    m_valM_o     = mem_rd ? dmem_rdata_i : '0;
    m_stat_o     = ((mem_rd | mem_wr) & dmem_error_i) ? SADR : mr_stat;
  end

  assign m_icode_o = mr_icode;
  assign m_valE_o  = mr_valE;
  assign m_dstE_o  = mr_dstE;
  assign m_dstM_o  = mr_dstM;

  assign w_hold = w_stall_i | exc_q;
  assign w_next = {m_stat_o, mr_icode, mr_valE, m_valM_o, mr_dstE, mr_dstM};

  pipe_reg #(
    .W      (PR_W),
    .BUBBLE (PR_BUBBLE)
  ) u_w_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .stall_i  (w_hold),
    .bubble_i (1'b0),
    .d_i      (w_next),
    .q_o      (w_reg)
  );

  assign {W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o} = w_reg;

  always_comb begin
    exc_d = exc_q;
    if (!w_hold && (m_stat_o != SAOK)) begin
      exc_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end

  // A bubble in W already carries AOK, so W's status is the CPU status.
  assign cpu_stat_o = W_stat_o;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Y86-64 pipeline memory stage, sitting directly upstream of the data RAM.
- Holds the E→M pipeline register and decodes icode into RAM read/write controls, address and write data.
- Merges the RAM read data and address error into stage status, then captures the result in the M→W pipeline register.
- Also exports the M-stage forwarding values and the sticky CPU status.

Parameters:
- DATA_W, 64, data and valE/valA width (matches `DATA_BUS`)
- ADDR_W, 64, RAM address width (matches `ADDR_BUS`)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- e_stat_i  in  3  execute-stage status (AOK=1, HLT=2, ADR=3, INS=4)
- e_icode_i  in  4  execute-stage icode
- e_valE_i  in  DATA_W  ALU result
- e_valA_i  in  DATA_W  operand A / return address
- e_dstE_i, e_dstM_i  in  4 each  destination registers (RNONE=4'hF)
- m_stall_i, m_bubble_i  in  1 each  M-register control from pipeline control
- w_stall_i  in  1  W-register stall from pipeline control
- dmem_r_en_o, dmem_w_en_o  out  1 each  RAM read/write enables
- dmem_addr_o  out  ADDR_W  RAM byte address
- dmem_wdata_o  out  DATA_W  RAM write data
- dmem_rdata_i  in  DATA_W  RAM combinational read data
- dmem_error_i  in  1  RAM address-out-of-range flag
- m_stat_o  out  3  M-stage status after memory access (forwarding/control)
- m_icode_o  out  4  M-stage icode
- m_valE_o, m_valM_o  out  DATA_W each  M-stage forwarding values
- m_dstE_o, m_dstM_o  out  4 each  M-stage forwarding destinations
- W_stat_o, W_icode_o  out  3 / 4  W-register fields
- W_valE_o, W_valM_o  out  DATA_W each  W-register fields
- W_dstE_o, W_dstM_o  out  4 each  W-register fields
- cpu_stat_o  out  3  architectural status

Behaviour:
- Reset (asynchronous, any cycle, including mid-store):
  - M and W registers load the bubble value: stat=AOK, icode=NOP(1), valE=valA=valM=0, dstE=dstM=RNONE.
  - exc_q is cleared and cpu_stat_o=AOK.
  - With reset asserted, dmem_r_en_o=dmem_w_en_o=0.
- M register updates on each clk_i edge:
  - m_bubble_i=1 loads the bubble value; bubble has priority over stall.
  - Otherwise m_stall_i=1 holds the current contents.
  - Otherwise it loads the E inputs.
- Access decode (combinational from the M register):
  - read = icode ∈ {MRMOVQ 5, POPQ B, RET 9}
  - write = icode ∈ {RMMOVQ 4, PUSHQ A, CALL 8}
  - dmem_addr_o = valA for POPQ/RET, otherwise valE.
  - dmem_wdata_o = valA.
- Enables:
  - dmem_r_en_o = read.
  - dmem_w_en_o = write & ~dmem_error_i & ~exc_q & (M.stat==AOK) & (W_stat_o==AOK).
  - Stores are therefore suppressed behind or under any exception.
- m_valM_o = read ? dmem_rdata_i : 0. The RAM read is combinational, so there is zero added latency.
- m_stat_o = ADR when (read|write) & dmem_error_i, otherwise M.stat.
- m_icode_o, m_valE_o, m_dstE_o, m_dstM_o pass through the M register.
- W register:
  - Holds when w_stall_i=1 or exc_q=1.
  - Otherwise loads {m_stat_o, icode, valE, m_valM_o, dstE, dstM}.
- exc_q (sticky):
  - Set on the edge where the W register loads a stat ≠ AOK.
  - Cleared only by reset.
  - While set, the W register is frozen and stores are blocked.
- cpu_stat_o = W_stat_o, except that a bubble (AOK) in W reports AOK.
- Store write-through is one cycle: the RAM commits on the same edge that advances the M register.
- A stalled M register holding a store re-asserts dmem_w_en_o every cycle. This is idempotent, and pipeline control must not stall M on a store; the bench flags it as an assertion.

Decomposition:
- Shared package/defines: icode constants (INOP, IRMMOVQ…IPOPQ), stat codes (SAOK, SHLT, SADR, SINS), RNONE, and a bubble-value constant for each register field.
- Natural sub-module: pipe_reg (width-parameterised, async-reset register with stall/bubble and reset/bubble value).
  - Instantiated twice, once for M and once for W.

Test Plan:
- MRMOVQ load: valE=0x10, RAM[0x10]=0x1122334455667788 → dmem_r_en_o=1, m_valM_o=0x1122334455667788; next edge W_valM_o equals it and W_dstM_o=e_dstM.
- PUSHQ store: valE=0x80, valA=0xDEAD → dmem_w_en_o=1, addr=0x80, wdata=0xDEAD; a following MRMOVQ from 0x80 reads 0xDEAD.
- RET read: valA=0x200 → dmem_addr_o=0x200 (not valE), read only, no write.
- Out-of-range store: valE=MEM_SIZE+8 with dmem_error_i=1 → dmem_w_en_o=0, m_stat_o=ADR.
  - Next edge: W_stat_o=ADR, cpu_stat_o=ADR.
  - W stays frozen afterwards; a subsequent RMMOVQ in M gets dmem_w_en_o=0.
- Stall/bubble:
  - m_stall_i held for 3 cycles keeps the M contents.
  - m_bubble_i with m_stall_i both high → M becomes NOP/RNONE.
  - w_stall_i holds W_valE_o.
- Async reset mid-store: rst_i asserted between edges → dmem_w_en_o drops immediately, all W outputs return to bubble values, and the memory location is unchanged.
